// File: rtl/demux_seq_ctrl.sv
// Rotating 1-to-8 demux controller: steps through the enabled channels and drives each accepted bit for DRIVE_CYCLES cycles.
// Optional transfer counter output xfer_cnt is enabled by defining DEMUX_SEQ_CTRL_CNT_EN.
module demux_seq_ctrl #(
  parameter int unsigned DRIVE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] chan_en,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic [2:0] sel,
  output logic [7:0] y,
  output logic [7:0] strb,
  output logic       sweep_done,
  output logic [1:0] dbg_state
`ifdef DEMUX_SEQ_CTRL_CNT_EN
  ,
  output logic [7:0] xfer_cnt
`endif
);

  // Handshake: a bit moves only in a cycle where in_valid && in_ready are both high.
  // in_ready never depends on in_valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    READY = 2'd2,
    DRIVE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] y_q, y_d;
  logic [7:0] strb_q, strb_d;
  logic [2:0] next_sel;
  logic       last_drive;

  // Return the first enabled index at or after start, wrapping 7 -> 0.
  function automatic logic [2:0] first_from(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    first_from = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (mask[idx]) first_from = idx;
    end
  endfunction

  assign next_sel   = first_from(chan_en, sel_q + 3'd1);
  assign last_drive = (cnt_q == 4'(DRIVE_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    strb_d     = strb_q;
    in_ready   = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (chan_en != 8'h00) state_d = SEEK;
      end
      SEEK: begin
        if (chan_en == 8'h00) begin
          state_d = IDLE;
        end else begin
          sel_d   = first_from(chan_en, sel_q);
          state_d = READY;
        end
      end
      READY: begin
        if (!chan_en[sel_q]) begin
          state_d = SEEK;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_d = DRIVE;
            cnt_d   = 4'd0;
            strb_d  = 8'h01 << sel_q;
            y_d     = {7'h00, in_data} << sel_q;
          end
        end
      end
      DRIVE: begin
        if (last_drive) begin
          cnt_d  = 4'd0;
          y_d    = 8'h00;
          strb_d = 8'h00;
          // The mask is re-read only here, so a mid-drive change never cuts the strobe short.
          if (chan_en == 8'h00) begin
            state_d = IDLE;
          end else begin
            sel_d      = next_sel;
            state_d    = READY;
            sweep_done = (next_sel <= sel_q);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= 4'd0;
      y_q     <= 8'h00;
      strb_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      strb_q  <= strb_d;
    end
  end

  assign sel       = sel_q;
  assign y         = y_q;
  assign strb      = strb_q;
  assign dbg_state = state_q;

`ifdef DEMUX_SEQ_CTRL_CNT_EN
  logic [7:0] xfer_cnt_q;
  logic       xfer;

  assign xfer = in_ready && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= 8'd0;
    end else if (xfer && (xfer_cnt_q != 8'hFF)) begin
      xfer_cnt_q <= xfer_cnt_q + 8'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_demux_seq_ctrl.sv
// Bench for demux_seq_ctrl: one instance with DRIVE_CYCLES=1, one with DRIVE_CYCLES=3, each with its own reset.
// Expected drive cycles {sweep_done, sel, strb, y} are queued by the tests and consumed by per-instance monitors.
module tb_demux_seq_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READY = 2'd2;

  logic       clk = 1'b0;
  logic       rst1_n = 1'b1;
  logic       rst3_n = 1'b1;
  logic [7:0] chan_en = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;

  logic       in_ready1, sweep1, in_ready3, sweep3;
  logic [2:0] sel1, sel3;
  logic [7:0] y1, strb1, y3, strb3;
  logic [1:0] st1, st3;
`ifdef DEMUX_SEQ_CTRL_CNT_EN
  logic [7:0] xfer_cnt1, xfer_cnt3;
`endif

  logic [19:0] exp1_q[$];
  logic [19:0] exp3_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  demux_seq_ctrl #(.DRIVE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .chan_en(chan_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .sel(sel1), .y(y1), .strb(strb1), .sweep_done(sweep1), .dbg_state(st1)
`ifdef DEMUX_SEQ_CTRL_CNT_EN
    , .xfer_cnt(xfer_cnt1)
`endif
  );

  demux_seq_ctrl #(.DRIVE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .chan_en(chan_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready3), .sel(sel3), .y(y3), .strb(strb3), .sweep_done(sweep3), .dbg_state(st3)
`ifdef DEMUX_SEQ_CTRL_CNT_EN
    , .xfer_cnt(xfer_cnt3)
`endif
  );

  // Any nonzero drive activity must match the next queued expectation.
  always @(negedge clk) begin
    if (strb1 !== 8'h00 || y1 !== 8'h00 || sweep1 !== 1'b0) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_drive got %h required none", {sweep1, sel1, strb1, y1});
      end else begin
        logic [19:0] e;
        e = exp1_q.pop_front();
        if ({sweep1, sel1, strb1, y1} !== e) begin
          errors++;
          $display("FAIL dut1_drive got %h required %h", {sweep1, sel1, strb1, y1}, e);
        end
      end
      checks++;
      if (in_ready1 !== 1'b0) begin
        errors++;
        $display("FAIL dut1_ready_in_drive got %b required 0", in_ready1);
      end
      last_cyc1 <= cyc;
    end
  end

  always @(negedge clk) begin
    if (strb3 !== 8'h00 || y3 !== 8'h00 || sweep3 !== 1'b0) begin
      checks++;
      if (exp3_q.size() == 0) begin
        errors++;
        $display("FAIL dut3_unexpected_drive got %h required none", {sweep3, sel3, strb3, y3});
      end else begin
        logic [19:0] e;
        e = exp3_q.pop_front();
        if ({sweep3, sel3, strb3, y3} !== e) begin
          errors++;
          $display("FAIL dut3_drive got %h required %h", {sweep3, sel3, strb3, y3}, e);
        end
      end
      checks++;
      if (in_ready3 !== 1'b0) begin
        errors++;
        $display("FAIL dut3_ready_in_drive got %b required 0", in_ready3);
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bit(input int which, input logic b);
    logic got;
    got = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((which == 1) ? in_ready1 : in_ready3) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout dut%0d got in_ready=0 required 1", which);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int which, input int bound);
    int n;
    n = 0;
    while (((which == 1) ? exp1_q.size() : exp3_q.size()) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (((which == 1) ? exp1_q.size() : exp3_q.size()) != 0) begin
      errors++;
      $display("FAIL drain_dut%0d got %0d pending required 0", which,
               (which == 1) ? exp1_q.size() : exp3_q.size());
      if (which == 1) exp1_q.delete(); else exp3_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    #1;
    checks++;
    if ({in_ready1, sel1, y1, strb1, sweep1, st1} !== 23'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %h required 0", {in_ready1, sel1, y1, strb1, sweep1, st1});
    end
    checks++;
    if ({in_ready3, sel3, y3, strb3, sweep3, st3} !== 23'd0) begin
      errors++;
      $display("FAIL reset_dut3 got %h required 0", {in_ready3, sel3, y3, strb3, sweep3, st3});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sweep_all();
    int start;
    do_reset();
    for (int i = 0; i < 12; i++)
      exp1_q.push_back({(i % 8) == 7, 3'(i % 8), 8'(1 << (i % 8)), 8'(1 << (i % 8))});
    chan_en  = 8'hFF;
    in_data  = 1'b1;
    in_valid = 1'b1;
    rst1_n   = 1'b1;
    start    = cyc;
    wait_drain(1, 100);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (last_cyc1 !== start + 25) begin
      errors++;
      $display("FAIL sweep_timing got last strobe at +%0d required +25", last_cyc1 - start);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_sparse();
    do_reset();
    chan_en = 8'b1000_0100;
    exp1_q.push_back({1'b0, 3'd2, 8'h04, 8'h04});
    exp1_q.push_back({1'b1, 3'd7, 8'h80, 8'h00});
    exp1_q.push_back({1'b0, 3'd2, 8'h04, 8'h04});
    @(negedge clk);
    rst1_n = 1'b1;
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    in_valid = 1'b0;
    wait_drain(1, 20);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_chan();
    do_reset();
    chan_en  = 8'h00;
    in_valid = 1'b1;
    in_data  = 1'b1;
    @(negedge clk);
    rst1_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready1, sel1, y1, strb1} !== 20'd0) begin
        errors++;
        $display("FAIL no_chan cycle %0d got %h required 0", i, {in_ready1, sel1, y1, strb1});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_long_drive();
    logic [2:0] bits;
    bits = 3'b101;
    do_reset();
    chan_en = 8'h10;
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < 3; k++)
        exp3_q.push_back({k == 2, 3'd4, 8'h10, bits[t] ? 8'h10 : 8'h00});
    @(negedge clk);
    rst3_n = 1'b1;
    for (int t = 0; t < 3; t++) send_bit(3, bits[t]);
    in_valid = 1'b0;
    wait_drain(3, 30);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    chan_en = 8'h10;
    exp3_q.push_back({1'b0, 3'd4, 8'h10, 8'h10});
    @(negedge clk);
    rst3_n = 1'b1;
    send_bit(3, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst3_n = 1'b0;
    #1;
    checks++;
    if ({y3, strb3, sel3, in_ready3} !== 20'd0 || st3 !== S_IDLE) begin
      errors++;
      $display("FAIL mid_drive_reset got y=%h strb=%h sel=%0d st=%0d required all 0",
               y3, strb3, sel3, st3);
    end
    checks++;
    if (exp3_q.size() != 0) begin
      errors++;
      $display("FAIL mid_drive_first_cycle got %0d pending required 0", exp3_q.size());
      exp3_q.delete();
    end
    repeat (2) @(negedge clk);
    rst3_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (st3 !== S_READY || sel3 !== 3'd4) begin
      errors++;
      $display("FAIL after_reset_release got st=%0d sel=%0d required st=2 sel=4", st3, sel3);
    end
  endtask

  task automatic test_mask_change();
    do_reset();
    chan_en = 8'h01;
    for (int k = 0; k < 3; k++) exp3_q.push_back({1'b0, 3'd0, 8'h01, 8'h01});
    @(negedge clk);
    rst3_n = 1'b1;
    send_bit(3, 1'b1);
    chan_en  = 8'h08;
    in_valid = 1'b0;
    wait_drain(3, 10);
    repeat (2) @(negedge clk);
    checks++;
    if (st3 !== S_READY || sel3 !== 3'd3) begin
      errors++;
      $display("FAIL mask_change_advance got st=%0d sel=%0d required st=2 sel=3", st3, sel3);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (st3 !== S_READY || sel3 !== 3'd3 || in_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL ready_hold got st=%0d sel=%0d rdy=%b required st=2 sel=3 rdy=1",
               st3, sel3, in_ready3);
    end
  endtask

`ifdef DEMUX_SEQ_CTRL_CNT_EN
  task automatic test_cnt();
    do_reset();
    for (int i = 0; i < 300; i++)
      exp1_q.push_back({(i % 8) == 7, 3'(i % 8), 8'(1 << (i % 8)), 8'(1 << (i % 8))});
    chan_en  = 8'hFF;
    in_data  = 1'b1;
    in_valid = 1'b1;
    rst1_n   = 1'b1;
    wait_drain(1, 800);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (xfer_cnt1 !== 8'd255) begin
      errors++;
      $display("FAIL xfer_cnt_sat got %0d required 255", xfer_cnt1);
    end
    rst1_n = 1'b0;
    #1;
    checks++;
    if (xfer_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL xfer_cnt_reset got %0d required 0", xfer_cnt1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep_all();
    test_sparse();
    test_no_chan();
    test_long_drive();
    test_reset_mid_drive();
    test_mask_change();
`ifdef DEMUX_SEQ_CTRL_CNT_EN
    test_cnt();
`endif
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_seq_ctrl.md
DEMUX_SEQ_CTRL -- requirements
Module: demux_seq_ctrl

Interface
REQ-001 Parameter DRIVE_CYCLES, default 1, number of cycles a captured bit is driven on the selected output; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 chan_en  input  8  channel enable mask; bit i set = output i takes part in the rotation.
REQ-005 in_valid  input  1  upstream has a data bit.
REQ-006 in_data  input  1  data bit to route (demux d input).
REQ-007 in_ready  output  1  controller accepts in_data this cycle.
REQ-008 sel  output  3  current channel pointer (demux select).
REQ-009 y  output  8  registered demux outputs; y[sel] = captured bit while driving, all other bits 0.
REQ-010 strb  output  8  one-hot qualifier; strb[sel] = 1 while driving.
REQ-011 sweep_done  output  1  one-cycle pulse when the rotation wraps past the highest enabled channel.

Function
REQ-012 The FSM SHALL have states IDLE, SEEK, READY and DRIVE.
REQ-013 IDLE: in_ready = 0; chan_en != 0 -> SEEK; otherwise stay.
REQ-014 SEEK: sel <= lowest enabled index >= sel, wrapping 7->0; -> READY; chan_en == 0 -> IDLE.
REQ-015 READY: in_ready = chan_en[sel]; chan_en[sel] == 0 -> SEEK (no transfer that cycle).
REQ-016 A transfer SHALL occur only on in_valid && in_ready; in_data is captured and the FSM moves to DRIVE.
REQ-017 DRIVE: in_ready = 0; y[sel] = captured bit, strb[sel] = 1 for exactly DRIVE_CYCLES cycles, starting the cycle after the transfer.
REQ-018 On the final DRIVE cycle, sel <= next enabled index strictly after sel (wrapping); -> READY; chan_en == 0 -> IDLE, sel unchanged.
REQ-019 sweep_done SHALL pulse on the final DRIVE cycle when the next enabled index is <= the current sel (wrap, including single-channel mask).
REQ-020 Outside DRIVE, y and strb SHALL be 8'h00; sel SHALL be stable except on SEEK and final-DRIVE updates.
REQ-021 Peak throughput SHALL be one transfer per DRIVE_CYCLES+1 cycles.
REQ-022 chan_en changes during DRIVE SHALL not truncate the drive; the new mask applies at the pointer advance.
REQ-023 in_valid deasserted in READY SHALL hold the FSM in READY with sel unchanged.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, sel = 3'd0, y = 8'h00, strb = 8'h00, in_ready = 0, sweep_done = 0, drive counter = 0.
REQ-025 Reset asserted mid-DRIVE SHALL discard the captured bit with no further strobe.
REQ-026 First transition after reset release SHALL occur on the following rising edge.

Configuration
REQ-027 Macro DEMUX_SEQ_CTRL_CNT_EN defined: adds output xfer_cnt (8 bits), incremented per transfer, saturating at 255, cleared by reset.
REQ-028 Macro undefined: port xfer_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 chan_en=8'hFF, in_valid=1 constant, in_data=1, DRIVE_CYCLES=1 -> strb one-hot 0x01,0x02,...,0x80 every 2nd cycle, y == strb, sweep_done once after channel 7.
REQ-030 chan_en=8'b1000_0100, data 1,0,1 -> sel 2,7,2; y=0x04, then 0x00 with strb=0x80, then 0x04; sweep_done after channel 7 transfer.
REQ-031 chan_en=8'h00 after reset, in_valid=1 -> in_ready stays 0, y=strb=0, sel=0 for 20 cycles.
REQ-032 DRIVE_CYCLES=3, chan_en=8'h10 -> strb=0x10 held 3 cycles, in_ready low during them, sweep_done on every transfer.
REQ-033 rst_n low on 2nd DRIVE cycle (DRIVE_CYCLES=3) -> y, strb, sel zero immediately, state IDLE, no residual strobe after release.
REQ-034 With DEMUX_SEQ_CTRL_CNT_EN, 300 transfers -> xfer_cnt = 255; reset -> 0.
